seq_mul_mac: RTL and testbench

//  Parametrised sequential shift-add multiplier with multiply-accumulate.

---
 rtl/seq_mul_mac.sv | 165 ++++++++++++++++
 tb/tb_seq_mul_mac.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_mac.sv
// seq_mul_mac
//   Sequential shift-add multiplier with optional multiply-accumulate.
//   One multiplier bit is consumed per clock; a signed operation subtracts the
//   final partial product (MSB weight -2^(nb-1)). The finished result is
//   optionally added to the running accumulator, and the accumulator always
//   takes the new result.
//
// Ports
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     operands/mode valid
//   in_ready   out  1     operands can be accepted (IDLE only)
//   A          in   nb    multiplicand
//   B          in   nb    multiplier
//   op_signed  in   1     1: two's complement operands, 0: unsigned
//   op_acc     in   1     1: result = A*B + acc, 0: result = A*B
//   Product    out  2*nb  result, stable while out_valid=1
//   out_valid  out  1     Product valid
//   out_ready  in   1     consumer accepts Product
//   busy       out  1     operation in progress (CALC or DONE)

module seq_mul_mac #(
    parameter int nb = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [nb-1:0]   A,
    input  logic [nb-1:0]   B,
    input  logic            op_signed,
    input  logic            op_acc,
    output logic [2*nb-1:0] Product,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    localparam int PW = 2 * nb;
    localparam int CW = $clog2(nb);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic [PW-1:0]   mcand_q,     mcand_d;
    logic [nb-1:0]   mplier_q,    mplier_d;
    logic            signed_q,    signed_d;
    logic            acc_mode_q,  acc_mode_d;
    logic [PW-1:0]   sum_q,       sum_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [PW-1:0]   product_q,   product_d;
    logic [PW-1:0]   acc_q,       acc_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q,      busy_d;

    logic [PW-1:0]   term;
    logic [PW-1:0]   sum_next;
    logic [PW-1:0]   result;
    logic            last_iter;

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        signed_d    = signed_q;
        acc_mode_d  = acc_mode_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        acc_d       = acc_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        // Multiplicand is shifted left and multiplier right each iteration,
        // so bit k of B always sits at mplier_q[0] with A<<k alongside it.
        term      = mplier_q[0] ? mcand_q : '0;
        last_iter = (cnt_q == CW'(nb - 1));
        sum_next  = (signed_q && last_iter) ? (sum_q - term) : (sum_q + term);
        result    = sum_next + (acc_mode_q ? acc_q : '0);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d    = op_signed ? {{nb{A[nb-1]}}, A} : {{nb{1'b0}}, A};
                    mplier_d   = B;
                    signed_d   = op_signed;
                    acc_mode_d = op_acc;
                    sum_d      = '0;
                    cnt_d      = '0;
                    state_d    = CALC;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            CALC: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                sum_d    = sum_next;
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    product_d   = result;
                    acc_d       = result;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            signed_q    <= 1'b0;
            acc_mode_q  <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            signed_q    <= signed_d;
            acc_mode_q  <= acc_mode_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign Product   = product_q;

endmodule

// File: tb/tb_seq_mul_mac.sv
module tb_seq_mul_mac;

    localparam int NB = 8;
    localparam int PW = 2 * NB;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic          op_signed;
    logic          op_acc;
    logic [PW-1:0] product;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    seq_mul_mac #(.nb(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .op_signed (op_signed),
        .op_acc    (op_acc),
        .Product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] acc_model;
    int ready_mode;  // 0: hold low, 1: hold high, 2: random stalls

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [PW-1:0] model(input logic [NB-1:0] x, input logic [NB-1:0] y,
                                            input logic s, input logic ac,
                                            input logic [PW-1:0] accv);
        longint vx, vy, r;
        vx = s ? longint'($signed(x)) : longint'(x);
        vy = s ? longint'($signed(y)) : longint'(y);
        r  = vx * vy + (ac ? longint'(accv) : 64'sd0);
        return r[PW-1:0];
    endfunction

    // Consumer-side monitor: every accepted output is checked against the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", product, '1 ^ product);
            end else begin
                check("product", product, exp_q.pop_front());
            end
        end
    end

    // Single driver for out_ready.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("idle_timeout", {15'd0, in_ready}, 16'd1);
    endtask

    // Issue one operation; returns #1 after the accepting edge.
    task automatic do_op(input logic [NB-1:0] x, input logic [NB-1:0] y,
                         input logic s, input logic ac, input logic [PW-1:0] expv);
        wait_idle();
        a = x; b = y; op_signed = s; op_acc = ac; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(expv);
        acc_model = expv;
        #1;
        in_valid  = 1'b0;
        a         = NB'($urandom);
        b         = NB'($urandom);
        op_signed = 1'($urandom);
        op_acc    = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", PW'(exp_q.size()), '0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [PW-1:0] held;
        logic [NB-1:0] rx, ry;
        logic rs, rac;

        tests = 0; fails = 0; acc_model = '0;
        ready_mode = 1;
        in_valid = 1'b0; a = '0; b = '0; op_signed = 1'b0; op_acc = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {15'd0, in_ready},  16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_busy",      {15'd0, busy},      16'd0);
        check("rst_product",   product,            16'd0);
        rst_n = 1'b1;

        // 1. signed -128 * -128 and latency
        do_op(8'h80, 8'h80, 1'b1, 1'b0, 16'h4000);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", PW'(lat), PW'(NB));
        drain();

        // 2. corners
        do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01);
        do_op(8'hFF, 8'h01, 1'b1, 1'b0, 16'hFFFF);
        // 3. accumulate chain
        do_op(8'd3, 8'd4, 1'b0, 1'b0, 16'd12);
        do_op(8'd5, 8'd6, 1'b0, 1'b1, 16'd42);
        do_op(8'd2, 8'd2, 1'b0, 1'b0, 16'd4);
        drain();

        // 4. stall in DONE; in_valid pulses ignored
        ready_mode = 0;
        @(posedge clk); #1;
        do_op(8'd7, 8'd9, 1'b0, 1'b1, 16'd67);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        held = product;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            a = NB'($urandom); b = NB'($urandom);
            @(negedge clk);
            check("stall_valid",    {15'd0, out_valid}, 16'd1);
            check("stall_product",  product,            held);
            check("stall_in_ready", {15'd0, in_ready},  16'd0);
        end
        in_valid = 1'b1;
        ready_mode = 1;
        @(posedge clk); #1;   // out_ready rises
        @(posedge clk); #1;   // handshake edge: in_valid high but must not be accepted
        in_valid = 1'b0;
        check("done_no_accept_ready", {15'd0, in_ready}, 16'd1);
        check("done_no_accept_busy",  {15'd0, busy},     16'd0);
        drain();

        // 5. reset during CALC iteration 3
        do_op(8'd11, 8'd13, 1'b0, 1'b1, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        acc_model = '0;
        check("abort_out_valid", {15'd0, out_valid}, 16'd0);
        check("abort_in_ready",  {15'd0, in_ready},  16'd1);
        check("abort_busy",      {15'd0, busy},      16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'd2, 8'd3, 1'b0, 1'b1, 16'd6);
        drain();

        // 6. random with stalls
        ready_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            rx = NB'($urandom); ry = NB'($urandom);
            rs = 1'($urandom);  rac = 1'($urandom);
            if ((i % 50) == 0) begin rx = 8'h80; ry = 8'h80; rs = 1'b1; end
            do_op(rx, ry, rs, rac, model(rx, ry, rs, rac, acc_model));
        end
        ready_mode = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
